// File: rtl/expnorm_pipe.sv
// Exponent normalisation for the rounder: er - lz plus the trap wrap (+/-alpha),
// or emin for untrapped tiny results. Produces en and en+1 through a 2-stage valid/ready pipe.
module expnorm_pipe #(
    parameter int EW  = 11,
    parameter int LZW = 6,
    parameter int XW  = EW + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 db,
    input  logic signed [XW-1:0] er,
    input  logic [LZW-1:0]       lz,
    input  logic                 ovf_en,
    input  logic                 ovf1,
    input  logic                 unf_en,
    input  logic                 tiny,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [XW-1:0] en,
    output logic signed [XW-1:0] eni,
    output logic                 ovf_wrap,
    output logic                 unf_wrap,
    output logic                 den_force
);

    typedef enum logic [1:0] {M_NORM, M_OVF, M_UNF, M_DEN} mode_t;

    localparam logic signed [XW-1:0] ALPHA_DB = XW'(3 * (2 ** (EW - 2)));
    localparam logic signed [XW-1:0] ALPHA_SG = XW'(3 * (2 ** (8 - 2)));
    localparam logic signed [XW-1:0] ONE      = XW'(1);

    // Overflow trap wins over underflow trap when both are raised.
    function automatic mode_t sel_mode(input logic oe, input logic o1,
                                       input logic ue, input logic t);
        if (oe && o1)
            return M_OVF;
        else if (ue && t)
            return M_UNF;
        else if (t)
            return M_DEN;
        return M_NORM;
    endfunction

    function automatic logic signed [XW-1:0] norm_exp(input logic signed [XW-1:0] d,
                                                      input mode_t m, input logic dbl);
        logic signed [XW-1:0] a;
        a = dbl ? ALPHA_DB : ALPHA_SG;
        case (m)
            M_OVF:   return d - a;
            M_UNF:   return d + a;
            M_DEN:   return ONE;
            default: return d;
        endcase
    endfunction

    logic                 r_vld_p1;
    logic signed [XW-1:0] r_d_p1;
    mode_t                r_mode_p1;
    logic                 r_db_p1;

    logic                 r_vld_p2;
    logic signed [XW-1:0] r_en_p2;
    logic signed [XW-1:0] r_eni_p2;
    logic                 r_ovf_p2;
    logic                 r_unf_p2;
    logic                 r_den_p2;

    logic                 w_s2_load;
    logic                 w_s1_adv;
    logic signed [XW-1:0] w_d;
    logic signed [XW-1:0] w_en;
    logic signed [XW-1:0] w_eni;

    assign w_s2_load = ~r_vld_p2 | out_ready;
    assign w_s1_adv  = r_vld_p1 & w_s2_load;
    assign in_ready  = ~r_vld_p1 | w_s1_adv;

    assign w_d   = er - $signed({{(XW - LZW){1'b0}}, lz});
    assign w_en  = norm_exp(r_d_p1, r_mode_p1, r_db_p1);
    assign w_eni = w_en + ONE;

    // Stage 1: difference er - lz, trap mode and format select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_d_p1    <= '0;
            r_mode_p1 <= M_NORM;
            r_db_p1   <= 1'b0;
        end else if (in_ready) begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_d_p1    <= w_d;
                r_mode_p1 <= sel_mode(ovf_en, ovf1, unf_en, tiny);
                r_db_p1   <= db;
            end
        end
    end

    // Stage 2: wrapped exponent, its increment and the mode flags; held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2 <= 1'b0;
            r_en_p2  <= '0;
            r_eni_p2 <= '0;
            r_ovf_p2 <= 1'b0;
            r_unf_p2 <= 1'b0;
            r_den_p2 <= 1'b0;
        end else if (w_s2_load) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_en_p2  <= w_en;
                r_eni_p2 <= w_eni;
                r_ovf_p2 <= (r_mode_p1 == M_OVF);
                r_unf_p2 <= (r_mode_p1 == M_UNF);
                r_den_p2 <= (r_mode_p1 == M_DEN);
            end
        end
    end

    assign out_valid = r_vld_p2;
    assign en        = r_en_p2;
    assign eni       = r_eni_p2;
    assign ovf_wrap  = r_ovf_p2;
    assign unf_wrap  = r_unf_p2;
    assign den_force = r_den_p2;

endmodule
